// File: rtl/ppu_vram_port_regs_if.sv
// ----------------------------------------------------------------------------
// ppu_vram_port_regs_if
// Downstream VRAM handshake between the PPU register front end (master) and
// the VRAM setter/getter stage (slave).
//
// Handshake semantics:
//   The master holds vramAddress_OUT, vramData_OUT and accessRW_SEL_OUT
//   stable while accessTrigger_OUT is high and for one cycle after it falls.
//   The slave performs the access on the falling edge of accessTrigger_OUT.
//   There is no backpressure. For reads, the slave returns data with a
//   one-cycle vramReadValid_IN pulse. The master captures the data whenever
//   vramReadValid_IN is high while accessRW_SEL_OUT selects read.
//
// Signals:
//   vramAddress_OUT   15  master -> slave  access address
//   vramData_OUT       8  master -> slave  write data
//   accessRW_SEL_OUT   1  master -> slave  1 = read, 0 = write
//   accessTrigger_OUT  1  master -> slave  access strobe (acted on when it falls)
//   vramReadData_IN    8  slave -> master  read data
//   vramReadValid_IN   1  slave -> master  read data valid
// ----------------------------------------------------------------------------
interface ppu_vram_port_regs_if;
  logic [14:0] vramAddress_OUT;
  logic [7:0]  vramData_OUT;
  logic        accessRW_SEL_OUT;
  logic        accessTrigger_OUT;
  logic [7:0]  vramReadData_IN;
  logic        vramReadValid_IN;

  modport master (
    output vramAddress_OUT,
    output vramData_OUT,
    output accessRW_SEL_OUT,
    output accessTrigger_OUT,
    input  vramReadData_IN,
    input  vramReadValid_IN
  );

  modport slave (
    input  vramAddress_OUT,
    input  vramData_OUT,
    input  accessRW_SEL_OUT,
    input  accessTrigger_OUT,
    output vramReadData_IN,
    output vramReadValid_IN
  );
endinterface

// File: rtl/ppu_vram_port_regs.sv
// ----------------------------------------------------------------------------
// ppu_vram_port_regs
// CPU-facing front end for PPU VRAM access: the PPUADDR ($2006) two-write
// address latch, and PPUDATA ($2007) reads/writes with auto-increment. Palette
// space ($3F00-$3FFF) is served from an internal 32 x 6-bit RAM. All other
// addresses go to the downstream stage through the vram interface.
//
// Ports:
//   clock_IN, reset_IN        clock; synchronous active-high reset
//   cpuSelect_EN              one-cycle strobe: CPU access to a PPU register
//   cpuRW_SEL                 1 = read, 0 = write
//   cpuRegAddr_IN[2:0]        register index
//   cpuData_IN[7:0]           CPU write data
//   cpuData_OUT[7:0]          CPU read data for $2007
//   increment32_SEL           address step select (INC_LARGE / INC_SMALL)
//   statusRead_EN             $2002 read strobe; clears the write toggle
//   busy_OUT                  downstream access in flight
//   overrun_OUT               sticky: a $2007 access was dropped
//   o_fsm_state[1:0]          debug view of the access FSM
//   vram (master)             downstream handshake, see ppu_vram_port_regs_if
// ----------------------------------------------------------------------------
module ppu_vram_port_regs #(
  parameter int TRIGGER_CYCLES = 2,
  parameter int INC_LARGE      = 32,
  parameter int INC_SMALL      = 1
) (
  input  logic                        clock_IN,
  input  logic                        reset_IN,
  input  logic                        cpuSelect_EN,
  input  logic                        cpuRW_SEL,
  input  logic [2:0]                  cpuRegAddr_IN,
  input  logic [7:0]                  cpuData_IN,
  output logic [7:0]                  cpuData_OUT,
  input  logic                        increment32_SEL,
  input  logic                        statusRead_EN,
  output logic                        busy_OUT,
  output logic                        overrun_OUT,
  output logic [1:0]                  o_fsm_state,
  ppu_vram_port_regs_if.master        vram
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_REL  = 2'd2
  } state_t;

  localparam int CNT_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRIGGER_CYCLES - 1);

  // Registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_toggle;
  logic [14:0]      r_temp;
  logic [14:0]      r_v;        // CPU-visible VRAM address (post-increment)
  logic [14:0]      r_addr;     // address driven downstream
  logic [7:0]       r_data;
  logic             r_rw;
  logic             r_trig;
  logic [7:0]       r_rbuf;
  logic [7:0]       r_cpu_data;
  logic             r_overrun;
  logic             r_pend_v;
  logic             r_pend_rw;
  logic [7:0]       r_pend_data;
  logic             r_local;    // in-flight access is a palette read; r_v already stepped
  logic             r_aovr;     // $2006 rewrote r_v during an access
  logic [5:0]       r_pal [32];

  // Next-state wires
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_toggle_nxt;
  logic [14:0]      w_temp_nxt;
  logic [14:0]      w_v_nxt;
  logic [14:0]      w_addr_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_rw_nxt;
  logic             w_trig_nxt;
  logic [7:0]       w_rbuf_nxt;
  logic [7:0]       w_cpu_data_nxt;
  logic             w_overrun_nxt;
  logic             w_pend_v_nxt;
  logic             w_pend_rw_nxt;
  logic [7:0]       w_pend_data_nxt;
  logic             w_local_nxt;
  logic             w_aovr_nxt;

  logic             w_sel6;
  logic             w_sel7;
  logic             w_direct;
  logic             w_launch;
  logic             w_l_rw;
  logic [7:0]       w_l_data;
  logic [14:0]      w_step;
  logic [14:0]      w_v_inc;
  logic [14:0]      w_new_addr;
  logic             w_is_pal;
  logic [4:0]       w_pal_idx;
  logic             w_pal_we;

  assign w_sel6     = cpuSelect_EN && (cpuRegAddr_IN == 3'd6) && !cpuRW_SEL;
  assign w_sel7     = cpuSelect_EN && (cpuRegAddr_IN == 3'd7);
  assign w_direct   = (r_state == S_IDLE) && !r_pend_v;
  assign w_step     = increment32_SEL ? 15'(INC_LARGE) : 15'(INC_SMALL);
  // Address space is 14 bits; bit 14 is always forced low after a step.
  assign w_v_inc    = (r_v + w_step) & 15'h3FFF;
  assign w_new_addr = {r_temp[14:8], cpuData_IN};
  assign w_is_pal   = (r_v[13:8] == 6'h3F);
  // $3F10/$14/$18/$1C mirror the backdrop entries $3F00/$04/$08/$0C.
  assign w_pal_idx  = (r_v[4] && (r_v[1:0] == 2'b00)) ? {1'b0, r_v[3:0]} : r_v[4:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_toggle_nxt    = r_toggle;
    w_temp_nxt      = r_temp;
    w_v_nxt         = r_v;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_rw_nxt        = r_rw;
    w_trig_nxt      = r_trig;
    w_rbuf_nxt      = r_rbuf;
    w_cpu_data_nxt  = r_cpu_data;
    w_overrun_nxt   = r_overrun;
    w_pend_v_nxt    = r_pend_v;
    w_pend_rw_nxt   = r_pend_rw;
    w_pend_data_nxt = r_pend_data;
    w_local_nxt     = r_local;
    w_aovr_nxt      = r_aovr;
    w_launch        = 1'b0;
    w_l_rw          = 1'b0;
    w_l_data        = 8'h00;
    w_pal_we        = 1'b0;

    if (vram.vramReadValid_IN && r_rw) w_rbuf_nxt = vram.vramReadData_IN;

    case (r_state)
      S_IDLE: begin
        // A queued access takes precedence over a new strobe in the same cycle.
        if (r_pend_v) begin
          w_launch     = 1'b1;
          w_l_rw       = r_pend_rw;
          w_l_data     = r_pend_data;
          w_pend_v_nxt = 1'b0;
        end else if (w_sel7) begin
          w_launch = 1'b1;
          w_l_rw   = cpuRW_SEL;
          w_l_data = cpuData_IN;
        end
      end
      S_TRIG: begin
        if (r_cnt == CNT_LAST) begin
          w_trig_nxt  = 1'b0;
          w_state_nxt = S_REL;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_REL: begin
        w_state_nxt = S_IDLE;
        if (r_aovr || r_local) begin
          w_addr_nxt = r_v;
        end else begin
          w_v_nxt    = w_v_inc;
          w_addr_nxt = w_v_inc;
        end
        w_local_nxt = 1'b0;
        w_aovr_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A strobe that cannot launch goes into the one-deep queue or is dropped.
    if (w_sel7 && !w_direct) begin
      if (!r_pend_v || (r_state == S_IDLE)) begin
        w_pend_v_nxt    = 1'b1;
        w_pend_rw_nxt   = cpuRW_SEL;
        w_pend_data_nxt = cpuData_IN;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end

    if (w_launch) begin
      if (w_is_pal) begin
        w_v_nxt = w_v_inc;
        if (w_l_rw) begin
          // Palette read: data comes from local RAM. The read buffer is still
          // refreshed from the nametable byte underneath ($3Fxx - $1000).
          w_cpu_data_nxt = {2'b00, r_pal[w_pal_idx]};
          w_addr_nxt     = r_v - 15'h1000;
          w_rw_nxt       = 1'b1;
          w_trig_nxt     = 1'b1;
          w_cnt_nxt      = '0;
          w_local_nxt    = 1'b1;
          w_state_nxt    = S_TRIG;
        end else begin
          w_pal_we   = 1'b1;
          w_addr_nxt = w_v_inc;
        end
      end else begin
        if (w_l_rw) w_cpu_data_nxt = r_rbuf;
        else        w_data_nxt     = w_l_data;
        w_rw_nxt    = w_l_rw;
        w_trig_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_TRIG;
      end
    end

    if (w_sel6) begin
      if (!r_toggle) begin
        w_temp_nxt = {1'b0, cpuData_IN[5:0], r_temp[7:0]};
      end else begin
        w_temp_nxt = w_new_addr;
        w_v_nxt    = w_new_addr;
        // While an access holds the bus, the new address is parked in r_v and
        // published when the FSM returns to IDLE.
        if (w_state_nxt == S_IDLE) begin
          w_addr_nxt = w_new_addr;
          w_aovr_nxt = 1'b0;
        end else begin
          w_aovr_nxt = 1'b1;
        end
      end
    end

    // Status read wins over the toggle flip of a coincident $2006 write.
    if (statusRead_EN)  w_toggle_nxt = 1'b0;
    else if (w_sel6)    w_toggle_nxt = ~r_toggle;
  end

  always_ff @(posedge clock_IN) begin
    if (reset_IN) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_toggle    <= 1'b0;
      r_temp      <= '0;
      r_v         <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rw        <= 1'b0;
      r_trig      <= 1'b0;
      r_rbuf      <= '0;
      r_cpu_data  <= '0;
      r_overrun   <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_rw   <= 1'b0;
      r_pend_data <= '0;
      r_local     <= 1'b0;
      r_aovr      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_toggle    <= w_toggle_nxt;
      r_temp      <= w_temp_nxt;
      r_v         <= w_v_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_rw        <= w_rw_nxt;
      r_trig      <= w_trig_nxt;
      r_rbuf      <= w_rbuf_nxt;
      r_cpu_data  <= w_cpu_data_nxt;
      r_overrun   <= w_overrun_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_rw   <= w_pend_rw_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_local     <= w_local_nxt;
      r_aovr      <= w_aovr_nxt;
    end
  end

  // Palette RAM keeps its contents across reset.
  always_ff @(posedge clock_IN) begin
    if (w_pal_we && !reset_IN) r_pal[w_pal_idx] <= w_l_data[5:0];
  end

  assign vram.vramAddress_OUT   = r_addr;
  assign vram.vramData_OUT      = r_data;
  assign vram.accessRW_SEL_OUT  = r_rw;
  assign vram.accessTrigger_OUT = r_trig;
  assign cpuData_OUT            = r_cpu_data;
  assign busy_OUT               = (r_state != S_IDLE);
  assign overrun_OUT            = r_overrun;
  assign o_fsm_state            = r_state;

endmodule

// File: tb/tb_ppu_vram_port_regs.sv
module tb_ppu_vram_port_regs;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       rw;
  logic [2:0] reg_a;
  logic [7:0] din;
  logic [7:0] dout;
  logic       inc32;
  logic       status_rd;
  logic       busy;
  logic       overrun;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_mis = 0;

  ppu_vram_port_regs_if vif ();

  ppu_vram_port_regs #(
    .TRIGGER_CYCLES(2),
    .INC_LARGE(32),
    .INC_SMALL(1)
  ) dut (
    .clock_IN        (clk),
    .reset_IN        (rst),
    .cpuSelect_EN    (sel),
    .cpuRW_SEL       (rw),
    .cpuRegAddr_IN   (reg_a),
    .cpuData_IN      (din),
    .cpuData_OUT     (dout),
    .increment32_SEL (inc32),
    .statusRead_EN   (status_rd),
    .busy_OUT        (busy),
    .overrun_OUT     (overrun),
    .o_fsm_state     (fsm_state),
    .vram            (vif.master)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    sel = 1'b1; rw = 1'b0; reg_a = a; din = d;
    tick();
    sel = 1'b0;
  endtask

  task automatic acc7(input logic r, input logic [7:0] d);
    sel = 1'b1; rw = r; reg_a = 3'd7; din = d;
    tick();
    sel = 1'b0; rw = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rw = 1'b0; reg_a = 3'd0; din = 8'h00;
    inc32 = 1'b0; status_rd = 1'b0;
    vif.vramReadData_IN = 8'h00; vif.vramReadValid_IN = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_addr", {1'b0, vif.vramAddress_OUT}, 16'h0000);
    chk("rst_data", {8'h0, vif.vramData_OUT}, 16'h0000);
    chk("rst_rw", {15'h0, vif.accessRW_SEL_OUT}, 16'h0);
    chk("rst_trig", {15'h0, vif.accessTrigger_OUT}, 16'h0);
    chk("rst_cpu", {8'h0, dout}, 16'h0000);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_ovr", {15'h0, overrun}, 16'h0);

    // $2006 $21,$08 then $2007 write $5A
    wr_reg(3'd6, 8'h21);
    chk("a6_hi_nochange", {1'b0, vif.vramAddress_OUT}, 16'h0000);
    wr_reg(3'd6, 8'h08);
    chk("a6_addr", {1'b0, vif.vramAddress_OUT}, 16'h2108);
    acc7(1'b0, 8'h5A);
    chk("w1_trig_c1", {15'h0, vif.accessTrigger_OUT}, 16'h1);
    chk("w1_data", {8'h0, vif.vramData_OUT}, 16'h005A);
    chk("w1_rw", {15'h0, vif.accessRW_SEL_OUT}, 16'h0);
    chk("w1_busy", {15'h0, busy}, 16'h1);
    tick();
    chk("w1_trig_c2", {15'h0, vif.accessTrigger_OUT}, 16'h1);
    tick();
    chk("w1_trig_c3", {15'h0, vif.accessTrigger_OUT}, 16'h0);
    chk("w1_rel_addr", {1'b0, vif.vramAddress_OUT}, 16'h2108);
    chk("w1_rel_busy", {15'h0, busy}, 16'h1);
    tick();
    chk("w1_done_busy", {15'h0, busy}, 16'h0);
    chk("w1_inc_addr", {1'b0, vif.vramAddress_OUT}, 16'h2109);

    // Increment by 32
    inc32 = 1'b1;
    wr_reg(3'd6, 8'h23); wr_reg(3'd6, 8'hE0);
    acc7(1'b0, 8'h00);
    tick(); tick(); tick();
    chk("inc32_addr", {1'b0, vif.vramAddress_OUT}, 16'h2400);
    // Palette-space read at $3FE0 with step 32: downstream $2FE0, wraps to $0000
    wr_reg(3'd6, 8'h3F); wr_reg(3'd6, 8'hE0);
    acc7(1'b1, 8'h00);
    chk("wrap_dn_addr", {1'b0, vif.vramAddress_OUT}, 16'h2FE0);
    chk("wrap_dn_rw", {15'h0, vif.accessRW_SEL_OUT}, 16'h1);
    tick(); tick(); tick();
    chk("wrap_addr", {1'b0, vif.vramAddress_OUT}, 16'h0000);
    inc32 = 1'b0;

    // Status read clears toggle
    wr_reg(3'd6, 8'h3F);
    status_rd = 1'b1; tick(); status_rd = 1'b0;
    wr_reg(3'd6, 8'h20);
    chk("st_hi_nochange", {1'b0, vif.vramAddress_OUT}, 16'h0000);
    wr_reg(3'd6, 8'h00);
    chk("st_clear_addr", {1'b0, vif.vramAddress_OUT}, 16'h2000);
    // Coincident status read: write uses old toggle (hi byte), then cleared
    status_rd = 1'b1; wr_reg(3'd6, 8'h3F); status_rd = 1'b0;
    wr_reg(3'd6, 8'h21); wr_reg(3'd6, 8'h00);
    chk("st_coinc_addr", {1'b0, vif.vramAddress_OUT}, 16'h2100);

    // Palette: write $3F10=$2A (mirrors $3F00), read back at $3F00
    wr_reg(3'd6, 8'h3F); wr_reg(3'd6, 8'h10);
    acc7(1'b0, 8'h2A);
    chk("pal_w_notrig", {15'h0, vif.accessTrigger_OUT}, 16'h0);
    chk("pal_w_nobusy", {15'h0, busy}, 16'h0);
    chk("pal_w_inc", {1'b0, vif.vramAddress_OUT}, 16'h3F11);
    wr_reg(3'd6, 8'h3F); wr_reg(3'd6, 8'h00);
    acc7(1'b1, 8'h00);
    chk("pal_r_data", {8'h0, dout}, 16'h002A);
    chk("pal_r_trig", {15'h0, vif.accessTrigger_OUT}, 16'h1);
    chk("pal_r_dnaddr", {1'b0, vif.vramAddress_OUT}, 16'h2F00);
    tick(); tick();
    vif.vramReadValid_IN = 1'b1; vif.vramReadData_IN = 8'h77;
    tick();
    vif.vramReadValid_IN = 1'b0;
    chk("pal_r_inc", {1'b0, vif.vramAddress_OUT}, 16'h3F01);

    // Buffered reads at $2000/$2001/$2002
    wr_reg(3'd6, 8'h20); wr_reg(3'd6, 8'h00);
    acc7(1'b1, 8'h00);
    chk("rd1_stale", {8'h0, dout}, 16'h0077);
    tick(); tick();
    vif.vramReadValid_IN = 1'b1; vif.vramReadData_IN = 8'h11;
    tick();
    vif.vramReadValid_IN = 1'b0;
    chk("rd1_inc", {1'b0, vif.vramAddress_OUT}, 16'h2001);
    acc7(1'b1, 8'h00);
    chk("rd2_data", {8'h0, dout}, 16'h0011);
    tick(); tick();
    vif.vramReadValid_IN = 1'b1; vif.vramReadData_IN = 8'h22;
    tick();
    vif.vramReadValid_IN = 1'b0;
    acc7(1'b1, 8'h00);
    chk("rd3_data", {8'h0, dout}, 16'h0022);
    tick(); tick(); tick();
    chk("rd3_inc", {1'b0, vif.vramAddress_OUT}, 16'h2003);

    // Three back-to-back writes: second queued, third dropped
    acc7(1'b0, 8'hA1);
    chk("bb1_addr", {1'b0, vif.vramAddress_OUT}, 16'h2003);
    chk("bb1_data", {8'h0, vif.vramData_OUT}, 16'h00A1);
    acc7(1'b0, 8'hB2);
    chk("bb2_noovr", {15'h0, overrun}, 16'h0);
    acc7(1'b0, 8'hC3);
    chk("bb3_ovr", {15'h0, overrun}, 16'h1);
    tick();
    chk("bb1_done_addr", {1'b0, vif.vramAddress_OUT}, 16'h2004);
    chk("bb1_done_busy", {15'h0, busy}, 16'h0);
    tick();
    chk("bb2_trig", {15'h0, vif.accessTrigger_OUT}, 16'h1);
    chk("bb2_data", {8'h0, vif.vramData_OUT}, 16'h00B2);
    chk("bb2_addr", {1'b0, vif.vramAddress_OUT}, 16'h2004);
    tick(); tick(); tick();
    chk("bb2_done_addr", {1'b0, vif.vramAddress_OUT}, 16'h2005);
    chk("bb2_done_busy", {15'h0, busy}, 16'h0);
    tick();
    chk("bb3_dropped", {15'h0, vif.accessTrigger_OUT}, 16'h0);
    chk("bb_ovr_sticky", {15'h0, overrun}, 16'h1);

    // $2006 rewrite during an access replaces the post-increment address
    acc7(1'b0, 8'h44);
    wr_reg(3'd6, 8'h21);
    chk("ovr6_hold1", {1'b0, vif.vramAddress_OUT}, 16'h2005);
    wr_reg(3'd6, 8'h50);
    chk("ovr6_hold2", {1'b0, vif.vramAddress_OUT}, 16'h2005);
    tick();
    chk("ovr6_addr", {1'b0, vif.vramAddress_OUT}, 16'h2150);
    chk("ovr6_busy", {15'h0, busy}, 16'h0);

    // Other registers and $2006 reads have no effect
    wr_reg(3'd0, 8'hFF);
    chk("reg0_notrig", {15'h0, vif.accessTrigger_OUT}, 16'h0);
    sel = 1'b1; rw = 1'b1; reg_a = 3'd6; din = 8'h3F; tick(); sel = 1'b0; rw = 1'b0;
    wr_reg(3'd6, 8'h12); wr_reg(3'd6, 8'h34);
    chk("rd6_noeffect", {1'b0, vif.vramAddress_OUT}, 16'h1234);

    // Reset in the middle of TRIG
    acc7(1'b0, 8'h99);
    chk("rstmid_trig", {15'h0, vif.accessTrigger_OUT}, 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_trig0", {15'h0, vif.accessTrigger_OUT}, 16'h0);
    chk("rstmid_addr0", {1'b0, vif.vramAddress_OUT}, 16'h0000);
    chk("rstmid_busy", {15'h0, busy}, 16'h0);
    chk("rstmid_ovr", {15'h0, overrun}, 16'h0);
    chk("rstmid_state", {14'h0, fsm_state}, 16'h0);
    tick(); tick();
    chk("rstmid_noinc", {1'b0, vif.vramAddress_OUT}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
